mips_io_bridge: RTL and testbench
=================================

# mips_io_bridge

System bridge between the pipelined MIPS CPU's memory stage and its memory-mapped slaves: external data memory, Timer0 and Timer1. The block decodes each CPU data access by address, steers write strobes to exactly one slave, and multiplexes read data back to the CPU. The datapath is purely combinational. A single registered fault flag records out-of-map or malformed accesses.

## Interface
Parameters: none. Address map constants live in the shared package.
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- m_tmp_data_addr  in  32  CPU byte address
- m_tmp_data_wdata  in  32  CPU write data, already lane-aligned
- m_tmp_data_byteen  in  4  CPU byte enables; 0 = read or no access
- m_tmp_data_rdata  out  32  read data returned to the CPU
- m_data_addr  out  32  data-memory address
- m_data_wdata  out  32  data-memory write data
- m_data_byteen  out  4  data-memory byte enables
- m_data_rdata  in  32  data-memory read data
- timer0_addr  out  32  Timer0 address
- timer0_we  out  1  Timer0 write enable
- timer0_wd  out  32  Timer0 write data
- timer0_rd  in  32  Timer0 read data
- timer1_addr / timer1_we / timer1_wd / timer1_rd  same shape as the Timer0 ports
- bridge_fault  out  1  sticky fault flag

## Operation
- Address map (inclusive byte ranges):
  - DM: 0x0000_0000–0x0000_2FFF
  - T0: 0x0000_7F00–0x0000_7F0B
  - T1: 0x0000_7F10–0x0000_7F1B
  - Any other address is unmapped.
- Pass-through, unconditional:
  - m_data_addr, timer0_addr, timer1_addr = m_tmp_data_addr.
  - m_data_wdata, timer0_wd, timer1_wd = m_tmp_data_wdata.
- Write steering:
  - m_data_byteen = m_tmp_data_byteen when the address hits DM; otherwise 4'b0000.
  - timerN_we = 1 only when the address hits TN and byteen == 4'b1111.
  - A timer write with partial byteen (nonzero, not 1111) writes nothing.
- Read mux, selected by address regardless of byteen:
  - DM hit → m_data_rdata
  - T0 hit → timer0_rd
  - T1 hit → timer1_rd
  - unmapped → 32'h0000_0000
- Fault conditions, evaluated each cycle:
  - a write (byteen ≠ 0) to an unmapped address;
  - a partial-byteen write to T0 or T1.
- bridge_fault is set to 1 on the clock edge after any fault condition. It stays 1 until reset.
- At most one of {DM byteen nonzero, timer0_we, timer1_we} may be active in any cycle.

## Timing
- Every steering and read-mux output is combinational from its inputs in the same cycle, with zero latency.
- bridge_fault is the only register:
  - It is 0 on the first clk edge with reset = 0.
  - While reset = 0 it is held at 0, and fault conditions during that time are ignored.
- The combinational outputs are not gated by reset. The CPU holds byteen = 0 during reset.
- A fault and reset asserted in the same cycle: reset wins, so bridge_fault = 0.
- Boundary behaviour:
  - 0x0000_2FFF is in DM; 0x0000_3000 is unmapped.
  - 0x7F0B is in T0; 0x7F0C is unmapped.
  - 0x7F1B is in T1; 0x7F1C is unmapped.
- Upper address bits are fully decoded. For example, 0x8000_7F00 is unmapped.

## Structure
- Shared package: per-region base/limit constants (DM_BASE, DM_END, T0_BASE, T0_END, T1_BASE, T1_END) and the BYTEEN_FULL constant.
- One natural sub-module, `addr_decode`: address in, one-hot {hit_dm, hit_t0, hit_t1, hit_none} out. It is reused for both steering and the read mux.
- The top level contains the steering, the read mux and the fault register.

## Test plan
- DM write: addr 0x0000_1004, byteen 0011, wdata 0x1234_5678.
  - Expect m_data_byteen = 0011, m_data_wdata = 0x1234_5678, timer0_we = 0, timer1_we = 0, bridge_fault stays 0.
- Timer reads: timer0_rd = 0xAAAA_0001, timer1_rd = 0xBBBB_0002, m_data_rdata = 0xCCCC_0003.
  - addr 0x7F04 → m_tmp_data_rdata = 0xAAAA_0001.
  - addr 0x7F18 → 0xBBBB_0002.
  - addr 0x2FFC → 0xCCCC_0003.
  - addr 0x4000 → 0x0000_0000.
- Timer1 full write: addr 0x7F10, byteen 1111, wdata 0x0000_0009.
  - Expect timer1_we = 1, timer1_wd = 9, timer0_we = 0, m_data_byteen = 0000.
- Partial timer write: addr 0x7F00, byteen 0001.
  - Expect timer0_we = 0 and m_data_byteen = 0000.
  - bridge_fault = 1 after the next clk edge and still 1 ten cycles later.
- Unmapped write: addr 0x0000_3000, byteen 1111.
  - Expect no write strobes and bridge_fault rising after one edge.
  - Then drive reset = 0 for one edge: bridge_fault = 0.
- Reset priority: hold reset = 0 while issuing an unmapped write.
  - Expect bridge_fault to stay 0.
  - Release reset with byteen = 0: bridge_fault stays 0.

Source files
------------

// File: rtl/mips_io_bridge_pkg.sv
// ----------------------------------------------------------------------------
// mips_io_bridge_pkg
// Purpose : Shared address map and byte-enable constants for the MIPS I/O
//           bridge, plus a helper for inclusive range checks.
// Contents: DM/T0/T1 base and end addresses (inclusive), BYTEEN_FULL,
//           one-hot hit vector bit positions, addr_in_range().
// ----------------------------------------------------------------------------
package mips_io_bridge_pkg;

    localparam logic [31:0] DM_BASE = 32'h0000_0000;
    localparam logic [31:0] DM_END  = 32'h0000_2FFF;
    localparam logic [31:0] T0_BASE = 32'h0000_7F00;
    localparam logic [31:0] T0_END  = 32'h0000_7F0B;
    localparam logic [31:0] T1_BASE = 32'h0000_7F10;
    localparam logic [31:0] T1_END  = 32'h0000_7F1B;

    localparam logic [3:0] BYTEEN_FULL = 4'b1111;

    // Bit positions inside the one-hot hit vector {dm, t0, t1, none}.
    localparam int unsigned HIT_DM   = 3;
    localparam int unsigned HIT_T0   = 2;
    localparam int unsigned HIT_T1   = 1;
    localparam int unsigned HIT_NONE = 0;

    // Inclusive range check over the full 32-bit address.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] last);
        return (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/mips_io_bridge_addr_decode.sv
// ----------------------------------------------------------------------------
// mips_io_bridge_addr_decode
// Purpose : Fully decodes a 32-bit CPU byte address against the bridge map.
// Ports   : i_addr  - CPU byte address
//           o_hit   - one-hot {hit_dm, hit_t0, hit_t1, hit_none}
// ----------------------------------------------------------------------------
module mips_io_bridge_addr_decode
    import mips_io_bridge_pkg::*;
(
    input  logic [31:0] i_addr,
    output logic [3:0]  o_hit
);

    logic w_dm;
    logic w_t0;
    logic w_t1;

    assign w_dm = addr_in_range(i_addr, DM_BASE, DM_END);
    assign w_t0 = addr_in_range(i_addr, T0_BASE, T0_END);
    assign w_t1 = addr_in_range(i_addr, T1_BASE, T1_END);

    // Regions are disjoint, so exactly one bit is set.
    always_comb begin
        o_hit           = 4'b0000;
        o_hit[HIT_DM]   = w_dm;
        o_hit[HIT_T0]   = w_t0;
        o_hit[HIT_T1]   = w_t1;
        o_hit[HIT_NONE] = ~(w_dm | w_t0 | w_t1);
    end

endmodule

// File: rtl/mips_io_bridge.sv
// ----------------------------------------------------------------------------
// mips_io_bridge
// Purpose : Bridge between the MIPS memory stage and its memory-mapped slaves
//           (data memory, Timer0, Timer1). Combinational write steering and
//           read multiplexing, plus one sticky fault register.
// Ports   : clk, reset (sync, active-low)
//           m_tmp_data_*  - CPU side: addr, wdata, byteen in; rdata out
//           m_data_*      - data memory: addr, wdata, byteen out; rdata in
//           timer0_*/timer1_* - timers: addr, we, wd out; rd in
//           bridge_fault  - set on unmapped write or partial timer write,
//                           cleared only by reset
// ----------------------------------------------------------------------------
module mips_io_bridge
    import mips_io_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_tmp_data_addr,
    input  logic [31:0] m_tmp_data_wdata,
    input  logic [3:0]  m_tmp_data_byteen,
    output logic [31:0] m_tmp_data_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] timer0_addr,
    output logic        timer0_we,
    output logic [31:0] timer0_wd,
    input  logic [31:0] timer0_rd,
    output logic [31:0] timer1_addr,
    output logic        timer1_we,
    output logic [31:0] timer1_wd,
    input  logic [31:0] timer1_rd,
    output logic        bridge_fault
);

    logic [3:0] w_hit;
    logic       w_write;
    logic       w_full;
    logic       w_fault;
    logic       r_fault;

    mips_io_bridge_addr_decode u_addr_decode (
        .i_addr (m_tmp_data_addr),
        .o_hit  (w_hit)
    );

    assign w_write = (m_tmp_data_byteen != 4'b0000);
    assign w_full  = (m_tmp_data_byteen == BYTEEN_FULL);

    assign m_data_addr  = m_tmp_data_addr;
    assign timer0_addr  = m_tmp_data_addr;
    assign timer1_addr  = m_tmp_data_addr;
    assign m_data_wdata = m_tmp_data_wdata;
    assign timer0_wd    = m_tmp_data_wdata;
    assign timer1_wd    = m_tmp_data_wdata;

    // Timers only accept whole-word writes; partial writes are dropped.
    assign m_data_byteen = w_hit[HIT_DM] ? m_tmp_data_byteen : 4'b0000;
    assign timer0_we     = w_hit[HIT_T0] & w_full;
    assign timer1_we     = w_hit[HIT_T1] & w_full;

    always_comb begin
        m_tmp_data_rdata = 32'h0000_0000;
        unique case (w_hit)
            4'b1000: m_tmp_data_rdata = m_data_rdata;
            4'b0100: m_tmp_data_rdata = timer0_rd;
            4'b0010: m_tmp_data_rdata = timer1_rd;
            default: m_tmp_data_rdata = 32'h0000_0000;
        endcase
    end

    assign w_fault = w_write & (w_hit[HIT_NONE] |
                                ((w_hit[HIT_T0] | w_hit[HIT_T1]) & ~w_full));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fault <= 1'b0;
        end else if (w_fault) begin
            r_fault <= 1'b1;
        end
    end

    assign bridge_fault = r_fault;

endmodule

// File: tb/tb_mips_io_bridge.sv
// ----------------------------------------------------------------------------
// tb_mips_io_bridge
// Purpose : Self-checking bench for mips_io_bridge: a table of combinational
//           decode/steering/read-mux vectors plus hand-written sequences for
//           the sticky fault flag and reset priority.
// ----------------------------------------------------------------------------
module tb_mips_io_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] m_tmp_data_addr;
    logic [31:0] m_tmp_data_wdata;
    logic [3:0]  m_tmp_data_byteen;
    logic [31:0] m_tmp_data_rdata;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic [31:0] timer0_addr;
    logic        timer0_we;
    logic [31:0] timer0_wd;
    logic [31:0] timer0_rd;
    logic [31:0] timer1_addr;
    logic        timer1_we;
    logic [31:0] timer1_wd;
    logic [31:0] timer1_rd;
    logic        bridge_fault;

    int checks = 0;
    int errors = 0;

    mips_io_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .m_tmp_data_addr   (m_tmp_data_addr),
        .m_tmp_data_wdata  (m_tmp_data_wdata),
        .m_tmp_data_byteen (m_tmp_data_byteen),
        .m_tmp_data_rdata  (m_tmp_data_rdata),
        .m_data_addr       (m_data_addr),
        .m_data_wdata      (m_data_wdata),
        .m_data_byteen     (m_data_byteen),
        .m_data_rdata      (m_data_rdata),
        .timer0_addr       (timer0_addr),
        .timer0_we         (timer0_we),
        .timer0_wd         (timer0_wd),
        .timer0_rd         (timer0_rd),
        .timer1_addr       (timer1_addr),
        .timer1_we         (timer1_we),
        .timer1_wd         (timer1_wd),
        .timer1_rd         (timer1_rd),
        .bridge_fault      (bridge_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_dm_be;
        logic        exp_t0_we;
        logic        exp_t1_we;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        m_tmp_data_addr   = a;
        m_tmp_data_wdata  = wd;
        m_tmp_data_byteen = be;
        #2;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        // Non-faulting vectors only; fault behaviour is exercised below.
        vecs.push_back('{"dm_write",   32'h0000_1004, 32'h1234_5678, 4'b0011,
                         32'hCCCC_0003, 4'b0011, 1'b0, 1'b0});
        vecs.push_back('{"t0_read",    32'h0000_7F04, 32'h0,         4'b0000,
                         32'hAAAA_0001, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"t1_read",    32'h0000_7F18, 32'h0,         4'b0000,
                         32'hBBBB_0002, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"dm_read",    32'h0000_2FFC, 32'h0,         4'b0000,
                         32'hCCCC_0003, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"unm_read",   32'h0000_4000, 32'h0,         4'b0000,
                         32'h0000_0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"t1_write",   32'h0000_7F10, 32'h0000_0009, 4'b1111,
                         32'hBBBB_0002, 4'b0000, 1'b0, 1'b1});
        vecs.push_back('{"t0_write",   32'h0000_7F08, 32'hDEAD_BEEF, 4'b1111,
                         32'hAAAA_0001, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{"dm_full",    32'h0000_0000, 32'h0BAD_F00D, 4'b1111,
                         32'hCCCC_0003, 4'b1111, 1'b0, 1'b0});
        vecs.push_back('{"dm_last",    32'h0000_2FFF, 32'h0,         4'b0000,
                         32'hCCCC_0003, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"dm_past",    32'h0000_3000, 32'h0,         4'b0000,
                         32'h0000_0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"t0_last",    32'h0000_7F0B, 32'h0,         4'b0000,
                         32'hAAAA_0001, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"t0_past",    32'h0000_7F0C, 32'h0,         4'b0000,
                         32'h0000_0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"t1_last",    32'h0000_7F1B, 32'h0,         4'b0000,
                         32'hBBBB_0002, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"t1_past",    32'h0000_7F1C, 32'h0,         4'b0000,
                         32'h0000_0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"gap_t0_t1",  32'h0000_7F0F, 32'h0,         4'b0000,
                         32'h0000_0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{"upper_bits", 32'h8000_7F00, 32'h0,         4'b0000,
                         32'h0000_0000, 4'b0000, 1'b0, 1'b0});

        reset             = 1'b0;
        m_tmp_data_addr   = 32'h0;
        m_tmp_data_wdata  = 32'h0;
        m_tmp_data_byteen = 4'b0000;
        m_data_rdata      = 32'hCCCC_0003;
        timer0_rd         = 32'hAAAA_0001;
        timer1_rd         = 32'hBBBB_0002;

        edge_sample();
        edge_sample();
        chk("reset_fault", {31'b0, bridge_fault}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].byteen);
            chk({vecs[i].name, "_rdata"}, m_tmp_data_rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, "_dm_be"}, {28'b0, m_data_byteen}, {28'b0, vecs[i].exp_dm_be});
            chk({vecs[i].name, "_t0_we"}, {31'b0, timer0_we}, {31'b0, vecs[i].exp_t0_we});
            chk({vecs[i].name, "_t1_we"}, {31'b0, timer1_we}, {31'b0, vecs[i].exp_t1_we});
            chk({vecs[i].name, "_dm_addr"}, m_data_addr, vecs[i].addr);
            chk({vecs[i].name, "_t0_addr"}, timer0_addr, vecs[i].addr);
            chk({vecs[i].name, "_t1_addr"}, timer1_addr, vecs[i].addr);
            chk({vecs[i].name, "_dm_wd"}, m_data_wdata, vecs[i].wdata);
            chk({vecs[i].name, "_t0_wd"}, timer0_wd, vecs[i].wdata);
            chk({vecs[i].name, "_t1_wd"}, timer1_wd, vecs[i].wdata);
            edge_sample();
            chk({vecs[i].name, "_no_fault"}, {31'b0, bridge_fault}, 32'd0);
        end

        // Partial Timer0 write: dropped, flags a fault that sticks.
        drive(32'h0000_7F00, 32'h1111_2222, 4'b0001);
        chk("t0_partial_we", {31'b0, timer0_we}, 32'd0);
        chk("t0_partial_dm_be", {28'b0, m_data_byteen}, 32'd0);
        chk("t0_partial_pre_edge", {31'b0, bridge_fault}, 32'd0);
        edge_sample();
        chk("t0_partial_fault", {31'b0, bridge_fault}, 32'd1);
        m_tmp_data_byteen = 4'b0000;
        repeat (10) edge_sample();
        chk("t0_partial_sticky", {31'b0, bridge_fault}, 32'd1);

        // One reset edge clears it.
        @(negedge clk);
        reset = 1'b0;
        edge_sample();
        chk("clear_after_partial", {31'b0, bridge_fault}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Partial Timer1 write also faults.
        drive(32'h0000_7F14, 32'h0, 4'b1100);
        chk("t1_partial_we", {31'b0, timer1_we}, 32'd0);
        edge_sample();
        chk("t1_partial_fault", {31'b0, bridge_fault}, 32'd1);
        @(negedge clk);
        m_tmp_data_byteen = 4'b0000;
        reset = 1'b0;
        edge_sample();
        chk("clear_after_t1", {31'b0, bridge_fault}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Unmapped write: no strobes, fault after one edge, reset clears.
        drive(32'h0000_3000, 32'hFFFF_FFFF, 4'b1111);
        chk("unm_dm_be", {28'b0, m_data_byteen}, 32'd0);
        chk("unm_t0_we", {31'b0, timer0_we}, 32'd0);
        chk("unm_t1_we", {31'b0, timer1_we}, 32'd0);
        edge_sample();
        chk("unm_fault", {31'b0, bridge_fault}, 32'd1);
        @(negedge clk);
        m_tmp_data_byteen = 4'b0000;
        reset = 1'b0;
        edge_sample();
        chk("unm_reset_clear", {31'b0, bridge_fault}, 32'd0);

        // Reset held while an unmapped write is presented: reset wins.
        drive(32'h8000_7F00, 32'h0, 4'b1111);
        edge_sample();
        chk("reset_prio_1", {31'b0, bridge_fault}, 32'd0);
        edge_sample();
        chk("reset_prio_2", {31'b0, bridge_fault}, 32'd0);
        @(negedge clk);
        m_tmp_data_byteen = 4'b0000;
        reset = 1'b1;
        edge_sample();
        chk("release_idle", {31'b0, bridge_fault}, 32'd0);
        edge_sample();
        chk("release_idle_2", {31'b0, bridge_fault}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
